// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and types for the branch predictor
package branch_predictor_pkg;

  localparam int INST_BYTES = 4;
  // Sequential fetch advances by one instruction.
  localparam int PC_INC = INST_BYTES;

  // Operation applied to a direction counter on the update path.
  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_INC  = 2'd1,
    CTR_DEC  = 2'd2,
    CTR_INIT = 2'd3
  } ctr_op_e;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating direction counter next-value logic
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_cur,
  input  ctr_op_e             op,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
  // Weakly taken: only the MSB set.
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  // Next counter value: increments stop at all-ones, decrements stop at zero.
  always_comb begin
    ctr_next = ctr_cur;
    case (op)
      CTR_INC:  if (ctr_cur != CTR_MAX)  ctr_next = ctr_cur + CTR_BITS'(1);
      CTR_DEC:  if (ctr_cur != CTR_ZERO) ctr_next = ctr_cur - CTR_BITS'(1);
      CTR_INIT: ctr_next = CTR_WEAK;
      default:  ctr_next = ctr_cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with direction counters and perf counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int PERF_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [XLEN-1:0]      pred_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_pred_taken,
  input  logic [XLEN-1:0]      upd_pred_target,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [PERF_BITS-1:0] branch_count,
  output logic [PERF_BITS-1:0] mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  if (ENTRIES < 2 || (1 << IDX) != ENTRIES || IDX + 2 + TAG_BITS > XLEN || CTR_BITS < 1)
  begin : g_bad_params
    $error("branch_predictor: illegal parameter combination");
  end

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX-1:0]      pred_idx;
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] pred_tag;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  ctr_op_e             ctr_op;
  logic [CTR_BITS-1:0] ctr_next;
  logic                unused_pc_bits;

  assign pred_idx = pred_pc[IDX+1:2];
  assign pred_tag = pred_pc[IDX+1+TAG_BITS:IDX+2];
  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[IDX+1+TAG_BITS:IDX+2];

  // Instruction-offset and high PC bits take no part in indexing or tagging.
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  // Lookup reads the registered table, so a same-cycle update is not yet visible.
  assign pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken  = pred_hit && ctr_q[pred_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[pred_idx] : pred_pc + PC_STEP;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_STEP;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Pick the counter action: train on a hit, allocate weakly-taken on a taken miss.
  always_comb begin
    ctr_op = CTR_HOLD;
    if (upd_hit) ctr_op = upd_taken ? CTR_INC : CTR_DEC;
    else if (upd_taken) ctr_op = CTR_INIT;
  end

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_cur  (ctr_q[upd_idx]),
    .op       (ctr_op),
    .ctr_next (ctr_next)
  );

  // Table write-back from the resolving stage; reset clears every field and wins over updates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (upd_valid) begin
      if (ctr_op != CTR_HOLD) ctr_q[upd_idx] <= ctr_next;
      if (upd_taken) begin
        target_q[upd_idx] <= upd_target;
        if (!upd_hit) begin
          valid_q[upd_idx] <= 1'b1;
          tag_q[upd_idx]   <= upd_tag;
        end
      end
    end
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      if (branch_count != '1) branch_count <= branch_count + PERF_BITS'(1);
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + PERF_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [63:0] pred_pc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_pred_taken;
  logic [63:0] upd_pred_target;

  logic        pred_hit, pred_taken, mispredict;
  logic [63:0] pred_target, redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  logic        s_pred_hit, s_pred_taken, s_mispredict;
  logic [63:0] s_pred_target, s_redirect_pc;
  logic [3:0]  s_branch_count, s_mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor dut (
    .CLK              (CLK),
    .RST              (RST),
    .pred_pc          (pred_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_predictor #(.PERF_BITS(4)) dut_s (
    .CLK              (CLK),
    .RST              (RST),
    .pred_pc          (pred_pc),
    .pred_hit         (s_pred_hit),
    .pred_taken       (s_pred_taken),
    .pred_target      (s_pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (s_mispredict),
    .redirect_pc      (s_redirect_pc),
    .branch_count     (s_branch_count),
    .mispredict_count (s_mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup_chk(input string tag, input logic [63:0] pc,
                            input logic hit, input logic taken, input logic [63:0] target);
    pred_pc = pc;
    #1;
    expect_eq({tag, "_hit"}, 64'(pred_hit), 64'(hit));
    expect_eq({tag, "_taken"}, 64'(pred_taken), 64'(taken));
    expect_eq({tag, "_target"}, pred_target, target);
  endtask

  task automatic counts_chk(input string tag, input int bc, input int mc, input int sbc, input int smc);
    expect_eq({tag, "_bcnt"}, 64'(branch_count), 64'(bc));
    expect_eq({tag, "_mcnt"}, 64'(mispredict_count), 64'(mc));
    expect_eq({tag, "_s_bcnt"}, 64'(s_branch_count), 64'(sbc));
    expect_eq({tag, "_s_mcnt"}, 64'(s_mispredict_count), 64'(smc));
  endtask

  // Present one resolved branch for a single cycle, checking the combinational outcome first.
  task automatic do_upd(input string tag, input logic [63:0] pc, input logic taken,
                        input logic [63:0] target, input logic ptaken, input logic [63:0] ptarget,
                        input logic exp_misp, input logic [63:0] exp_redirect);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptarget;
    #1;
    expect_eq({tag, "_misp"}, 64'(mispredict), 64'(exp_misp));
    expect_eq({tag, "_redir"}, redirect_pc, exp_redirect);
    @(negedge CLK);
    upd_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    pred_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    lookup_chk("rst_0", 64'h0, 1'b0, 1'b0, 64'h4);
    lookup_chk("rst_40", 64'h40, 1'b0, 1'b0, 64'h44);
    lookup_chk("rst_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
    expect_eq("rst_misp_idle", 64'(mispredict), 64'h0);
    counts_chk("rst", 0, 0, 0, 0);

    // First taken branch allocates weakly taken.
    pred_pc = 64'h100;
    do_upd("alloc", 64'h100, 1'b1, 64'h80, 1'b0, 64'h104, 1'b1, 64'h80);
    counts_chk("alloc", 1, 1, 1, 1);
    lookup_chk("alloc_lk", 64'h100, 1'b1, 1'b1, 64'h80);

    // Train down 2 -> 1 -> 0 -> 0.
    do_upd("nt1", 64'h100, 1'b0, 64'h80, 1'b1, 64'h80, 1'b1, 64'h104);
    lookup_chk("nt1_lk", 64'h100, 1'b1, 1'b0, 64'h104);
    do_upd("nt2", 64'h100, 1'b0, 64'h80, 1'b0, 64'h104, 1'b0, 64'h104);
    lookup_chk("nt2_lk", 64'h100, 1'b1, 1'b0, 64'h104);
    do_upd("nt3", 64'h100, 1'b0, 64'h80, 1'b0, 64'h104, 1'b0, 64'h104);
    counts_chk("nt3", 4, 2, 4, 2);
    // Floor held at 0: one taken reaches 1 (still not taken), a second reaches 2.
    do_upd("up1", 64'h100, 1'b1, 64'h80, 1'b0, 64'h104, 1'b1, 64'h80);
    lookup_chk("up1_lk", 64'h100, 1'b1, 1'b0, 64'h104);
    do_upd("up2", 64'h100, 1'b1, 64'h80, 1'b0, 64'h104, 1'b1, 64'h80);
    lookup_chk("up2_lk", 64'h100, 1'b1, 1'b1, 64'h80);

    // Taken target mismatch alone is a mispredict.
    do_upd("tgt", 64'h100, 1'b1, 64'h88, 1'b1, 64'h80, 1'b1, 64'h88);
    lookup_chk("tgt_lk", 64'h100, 1'b1, 1'b1, 64'h88);
    counts_chk("tgt", 7, 5, 7, 5);

    // Alias at 0x140: same index, different tag, evicts 0x100.
    do_upd("alias", 64'h140, 1'b1, 64'h300, 1'b0, 64'h144, 1'b1, 64'h300);
    lookup_chk("alias_old", 64'h100, 1'b0, 1'b0, 64'h104);
    lookup_chk("alias_new", 64'h140, 1'b1, 1'b1, 64'h300);

    // Same-cycle lookup and update: read-before-write.
    pred_pc = 64'h200;
    #1;
    expect_eq("rbw_pre_hit", 64'(pred_hit), 64'h0);
    expect_eq("rbw_pre_target", pred_target, 64'h204);
    do_upd("rbw", 64'h200, 1'b1, 64'h240, 1'b0, 64'h204, 1'b1, 64'h240);
    lookup_chk("rbw_post", 64'h200, 1'b1, 1'b1, 64'h240);
    counts_chk("rbw", 9, 7, 9, 7);

    // Ten taken mispredicts on 0x400: counter saturates high, small perf counters saturate at 15.
    for (int i = 0; i < 10; i++)
      do_upd("sat", 64'h400, 1'b1, 64'h500, 1'b0, 64'h404, 1'b1, 64'h500);
    counts_chk("sat", 19, 17, 15, 15);
    // From saturated 3 one not-taken leaves 2, still predicting taken.
    do_upd("sat_nt", 64'h400, 1'b0, 64'h500, 1'b1, 64'h500, 1'b1, 64'h404);
    lookup_chk("sat_nt_lk", 64'h400, 1'b1, 1'b1, 64'h500);
    counts_chk("sat_nt", 20, 18, 15, 15);

    // Reset together with an update: reset wins.
    RST = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 64'h300;
    upd_taken = 1'b1;
    upd_target = 64'h700;
    @(negedge CLK);
    RST = 1'b0;
    upd_valid = 1'b0;
    lookup_chk("rst2_400", 64'h400, 1'b0, 1'b0, 64'h404);
    lookup_chk("rst2_300", 64'h300, 1'b0, 1'b0, 64'h304);
    lookup_chk("rst2_200", 64'h200, 1'b0, 1'b0, 64'h204);
    counts_chk("rst2", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with per-entry saturating direction counters, parametrised in address width, depth, tag width and counter width. The IF stage reads it every cycle with the fetch PC to choose the next PC. The stage that resolves branches (MEM in the current pipeline) writes it back. The block also flags mispredictions and keeps saturating performance counters, which the current always-predict-not-taken fetch path does not have.

## Interface
Parameters:
- XLEN, 64, address/data width
- ENTRIES, 16, table depth; power of two, ≥ 2
- TAG_BITS, 8, stored tag width; require log2(ENTRIES)+2+TAG_BITS ≤ XLEN
- CTR_BITS, 2, direction counter width; ≥ 1
- PERF_BITS, 32, performance counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- pred_pc  in  XLEN  IF fetch address
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted direction
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  a resolved branch is presented this cycle
- upd_pc  in  XLEN  branch instruction address
- upd_taken  in  1  actual direction
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe for this branch
- upd_pred_target  in  XLEN  predicted next PC carried down the pipe
- mispredict  out  1  the resolved branch was mispredicted
- redirect_pc  out  XLEN  correct next PC: upd_target if upd_taken, else upd_pc+4
- branch_count  out  PERF_BITS  resolved branches
- mispredict_count  out  PERF_BITS  mispredictions

## Operation
Address mapping:
- IDX = log2(ENTRIES)
- index = pc[IDX+1:2]
- tag = pc[IDX+1+TAG_BITS:IDX+2]

Entry contents: valid, tag, target (XLEN), ctr (CTR_BITS).

Lookup (combinational on pred_pc):
- pred_hit = valid & tag match.
- pred_taken = pred_hit & ctr[MSB].
- pred_target = entry target if pred_taken, else pred_pc+4. Addition wraps modulo 2^XLEN.

Mispredict detection (combinational):
- mispredict = upd_valid & (upd_taken ≠ upd_pred_taken | (upd_taken & upd_target ≠ upd_pred_target)).
- mispredict is 0 when upd_valid=0.

Update (registered, when upd_valid=1):
- Hit, taken: ctr saturating-increments (max 2^CTR_BITS−1); target ← upd_target.
- Hit, not taken: ctr saturating-decrements (min 0); target unchanged.
- Miss, taken: allocate or overwrite the entry. Set valid=1, tag, target, and ctr = 2^(CTR_BITS−1) (weakly taken).
- Miss, not taken: no table change.
- branch_count +1 per update. mispredict_count +1 when mispredict=1. Both saturate at all-ones and never wrap.

Reset behaviour:
- All valid bits, ctr, target, tag and performance counters are cleared to 0.
- After reset every lookup misses: pred_taken=0, pred_target=pred_pc+4, pred_hit=0.
- Reset asserted in the same cycle as upd_valid: reset wins and no update is applied.

## Timing
- Lookup and mispredict/redirect_pc have zero-cycle latency, combinational from their inputs.
- An update becomes visible to lookup on the cycle after the CLK edge that samples it.
- Lookup and update hitting the same index in the same cycle: lookup returns the pre-update contents (read-before-write).
- One update per cycle. Back-to-back updates to the same entry accumulate correctly, each step seeing the previous result.
- Performance counters update on the same edge as the table.

## Structure
- Shared package holds INST_BYTES=4 and the PC-increment constant. Parameter legality checks live in an elaboration-time assertion inside this block.
- One sub-module, bp_sat_counter: parametrised CTR_BITS next-value logic (inc/dec/init, saturating), instantiated once on the update path.
- Table storage is a register array indexed by the update index. No memory macro.

## Test plan
- Reset then lookups at pred_pc=0x0, 0x40, 0xFFFFFFFFFFFFFFFC → pred_hit=0, pred_taken=0, pred_target=0x4, 0x44, 0x0 (wrap).
- Update pc=0x100, taken, target=0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80, mispredict_count=1. Next cycle lookup 0x100 → hit, taken, target 0x80.
- Same branch updated not-taken twice → ctr 2→1→0. Lookup → hit, pred_taken=0, pred_target=0x104. Third not-taken update keeps ctr=0.
- Alias: pc 0x100 and 0x100+4·ENTRIES (same index, different tag). Taken update of the alias evicts the original entry, so lookup of 0x100 misses.
- Same-cycle lookup and update of 0x200 → lookup reflects old state; the following cycle reflects the new state.
- Preload branch_count to 2^PERF_BITS−1 (PERF_BITS=4 build) and update → count holds at 15. RST asserted with upd_valid=1 → table empty, counts 0.
